wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Arbitrates the single write port of one register file (scalar or vector) between the scalar pipeline's mem-stage result and the fixed-latency vector pipeline's final-stage result. The vector pipeline cannot stall, so a vector result that loses arbitration is parked in a small in-order buffer and drained later. The scalar side is back-pressured through `s_ready`, which feeds the core's full-stall logic. The block is instantiated once per register file, and `pending_mask` goes to decode-stage hazard logic.

## Interface
- `DATA_W`, default 32: write-data width; 128 for the vector-file instance.
- `BUF_DEPTH`, default 2: deferred-vector buffer entries, minimum 1.
- `STARVE_MAX`, default 4: consecutive scalar-blocked cycles before starvation override.
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `s_valid`  in  1: scalar mem stage has a result for this file.
- `s_dest`  in  5: scalar destination register.
- `s_data`  in  DATA_W: scalar result.
- `s_ready`  out  1: scalar result accepted this cycle. Combinational. When low with `s_valid` high, the scalar pipeline must hold.
- `v_valid`  in  1: vector pipeline final stage has a result for this file. Always accepted.
- `v_dest`  in  5: vector destination register.
- `v_data`  in  DATA_W: vector result.
- `v_newer`  in  1: vector result is younger than the concurrent scalar result. Meaningful only when `s_valid` is high.
- `wr_en`  out  1: register-file write enable. Registered.
- `wr_dest`  out  5: write address. Registered.
- `wr_data`  out  DATA_W: write data. Registered.
- `pending_mask`  out  32: bit r is set if any valid buffer entry targets register r. Combinational from buffer state.
- `buf_count`  out  $clog2(BUF_DEPTH+1): occupied buffer entries. Registered.

## Operation
- Circular FIFO of {dest, data}, BUF_DEPTH entries, with head/tail pointers wrapping modulo BUF_DEPTH.
- Exactly one winner per cycle, with winner selection in the following order:
  1. **Override.** Applies when `s_valid` is high, `starve_cnt >= STARVE_MAX`, `buf_count < BUF_DEPTH`, `pending_mask[s_dest]` is 0, and the following is false: `v_valid & ~v_newer & (v_dest == s_dest)`.
     - Scalar writes and `s_ready` is 1.
     - If `v_valid`, the vector result is pushed with no pop.
  2. **Buffer non-empty.** The head is written and popped.
     - If `v_valid`, the vector result is pushed in the same cycle; the count is unchanged.
     - `s_ready` is 0.
  3. **Buffer empty.** Behaviour depends on which inputs are valid:
     - `v_valid` only: write the vector result.
     - `s_valid` only: write the scalar result; `s_ready` is 1.
     - Both valid, `v_newer` is 0: write the vector result; `s_ready` is 0.
     - Both valid, `v_newer` is 1: write the scalar result; `s_ready` is 1; push the vector result.
  4. **Nothing valid.** `wr_en` is 0 next cycle.
- Push without pop occurs only when `buf_count < BUF_DEPTH`, so overflow is structurally impossible. An overflow is an assertion failure in verification.
- The buffer preserves vector program order. Scalar results never bypass an older write to the same destination.
- `starve_cnt` is 0..STARVE_MAX and saturates.
  - Increments when `s_valid & ~s_ready`.
  - Clears when `~s_valid` or `s_ready`.
- A held scalar request must keep `s_dest` and `s_data` stable. The arbiter does not latch them.

## Timing
- Reset state: `wr_en`=0, `wr_dest`=0, `wr_data`=0, `buf_count`=0, head/tail=0, `starve_cnt`=0, `pending_mask`=0, and `s_ready` is 0 while `s_valid` is 0.
- Latency: the winner is presented on `wr_*` in the cycle after selection, so the register-file write lands at the following edge.
- `buf_count` and `pending_mask` reflect a push or pop in the cycle after the edge that performs it.
- `rst` asserted mid-operation discards buffered entries immediately; no write is issued for them.
- Steady vector streaming with a non-empty buffer starves the scalar side for exactly STARVE_MAX cycles. Override fires on the next cycle, provided there is buffer room and no conflict.
- With BUF_DEPTH full, override is blocked and the scalar side waits for a vector bubble.

## Test plan
- **Scalar only.** After reset, `s_valid`=1, `s_dest`=3, `s_data`=0xA5 for one cycle -> `s_ready`=1; next cycle `wr_en`=1, `wr_dest`=3, `wr_data`=0xA5; `buf_count`=0.
- **Collision, vector newer.** `s`(dest 4, 0x11) and `v`(dest 5, 0x22) with `v_newer`=1 -> cycle+1 writes 4/0x11 and `buf_count`=1, `pending_mask`=0x20; cycle+2 writes 5/0x22 and `buf_count`=0.
- **Collision, vector older.** Same stimulus with `v_newer`=0 -> `s_ready`=0 in cycle 0 and 5/0x22 written; cycle 1 `s_ready`=1; 4/0x11 written in cycle 2.
- **Starvation.** Prime one buffer entry (dest 7), then hold `v_valid` every cycle (dests 8, 9, ...) and `s_valid` with dest 2 (BUF_DEPTH=2, STARVE_MAX=4) -> `s_ready`=0 for 4 cycles, 1 in the 5th; `buf_count` goes 1->2; vector writes remain in order.
- **WAW block.** Repeat the starvation case with `s_dest`=7 while dest 7 is buffered -> no override until the dest-7 entry is written; the scalar write follows it.
- **Reset mid-stream.** Assert `rst` with `buf_count`=2 -> `wr_en`, `buf_count` and `pending_mask` are 0 immediately; after release, neither buffered entry is ever written.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// ============================================================================
// Module      : wb_port_arbiter
// Description : Register-file write-port arbiter between the scalar mem-stage
//               result and the non-stallable vector final-stage result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int BUF_DEPTH  = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               s_valid,
  input  logic [4:0]                         s_dest,
  input  logic [DATA_W-1:0]                  s_data,
  output logic                               s_ready,
  input  logic                               v_valid,
  input  logic [4:0]                         v_dest,
  input  logic [DATA_W-1:0]                  v_data,
  input  logic                               v_newer,
  output logic                               wr_en,
  output logic [4:0]                         wr_dest,
  output logic [DATA_W-1:0]                  wr_data,
  output logic [31:0]                        pending_mask,
  output logic [$clog2(BUF_DEPTH+1)-1:0]     buf_count
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  localparam logic [CNT_W-1:0] c_depth      = CNT_W'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] c_last_ptr   = PTR_W'(BUF_DEPTH - 1);
  localparam logic [STV_W-1:0] c_starve_max = STV_W'(STARVE_MAX);

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic [BUF_DEPTH-1:0] vld_q, vld_d;
  logic              wr_en_q, wr_en_d;
  logic [4:0]        wr_dest_q, wr_dest_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic [4:0]        buf_dest_q [BUF_DEPTH];
  logic [DATA_W-1:0] buf_data_q [BUF_DEPTH];

  logic buf_empty;
  logic buf_full;
  logic conflict;
  logic override;
  logic push;
  logic pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == c_last_ptr) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (vld_q[i]) pending_mask[buf_dest_q[i]] = 1'b1;
    end
  end

  assign buf_empty = (count_q == '0);
  assign buf_full  = (count_q == c_depth);
  // An older concurrent vector write to the same register must land first.
  assign conflict  = v_valid & ~v_newer & (v_dest == s_dest);
  assign override  = s_valid & (starve_q >= c_starve_max) & ~buf_full &
                     ~pending_mask[s_dest] & ~conflict;

  always_comb begin
    s_ready   = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    wr_en_d   = 1'b0;
    wr_dest_d = wr_dest_q;
    wr_data_d = wr_data_q;
    if (override) begin
      s_ready   = 1'b1;
      wr_en_d   = 1'b1;
      wr_dest_d = s_dest;
      wr_data_d = s_data;
      push      = v_valid;
    end else if (!buf_empty) begin
      wr_en_d   = 1'b1;
      wr_dest_d = buf_dest_q[head_q];
      wr_data_d = buf_data_q[head_q];
      pop       = 1'b1;
      push      = v_valid;
    end else if (v_valid && (!s_valid || !v_newer)) begin
      wr_en_d   = 1'b1;
      wr_dest_d = v_dest;
      wr_data_d = v_data;
    end else if (s_valid) begin
      s_ready   = 1'b1;
      wr_en_d   = 1'b1;
      wr_dest_d = s_dest;
      wr_data_d = s_data;
      push      = v_valid;
    end
  end

  always_comb begin
    head_d = pop  ? ptr_inc(head_q) : head_q;
    tail_d = push ? ptr_inc(tail_q) : tail_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Clear before set: when full, a pop and push share the same slot.
    vld_d = vld_q;
    if (pop)  vld_d[head_q] = 1'b0;
    if (push) vld_d[tail_q] = 1'b1;
    if (!s_valid || s_ready)
      starve_d = '0;
    else if (starve_q == c_starve_max)
      starve_d = starve_q;
    else
      starve_d = starve_q + STV_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      vld_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_dest_q <= '0;
      wr_data_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      vld_q     <= vld_d;
      wr_en_q   <= wr_en_d;
      wr_dest_q <= wr_dest_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by vld_q.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_dest_q[tail_q] <= v_dest;
      buf_data_q[tail_q] <= v_data;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_dest   = wr_dest_q;
  assign wr_data   = wr_data_q;
  assign buf_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Directed vector bench for wb_port_arbiter (depth 2, starve 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic [4:0]  s_dest;
  logic [31:0] s_data;
  logic        s_ready;
  logic        v_valid;
  logic [4:0]  v_dest;
  logic [31:0] v_data;
  logic        v_newer;
  logic        wr_en;
  logic [4:0]  wr_dest;
  logic [31:0] wr_data;
  logic [31:0] pending_mask;
  logic [1:0]  buf_count;

  int checks   = 0;
  int failures = 0;

  wb_port_arbiter #(
    .DATA_W    (32),
    .BUF_DEPTH (2),
    .STARVE_MAX(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_dest      (s_dest),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .v_valid     (v_valid),
    .v_dest      (v_dest),
    .v_data      (v_data),
    .v_newer     (v_newer),
    .wr_en       (wr_en),
    .wr_dest     (wr_dest),
    .wr_data     (wr_data),
    .pending_mask(pending_mask),
    .buf_count   (buf_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sv;
    logic [4:0]  sd;
    logic [31:0] sdat;
    logic        vv;
    logic [4:0]  vd;
    logic [31:0] vdat;
    logic        vn;
    logic        e_rdy;
    logic        e_en;
    logic [4:0]  e_dest;
    logic [31:0] e_data;
    logic [1:0]  e_cnt;
    logic [31:0] e_mask;
  } vec_t;

  function automatic vec_t mk(input logic sv, input logic [4:0] sd, input logic [31:0] sdat,
                              input logic vv, input logic [4:0] vd, input logic [31:0] vdat,
                              input logic vn, input logic e_rdy, input logic e_en,
                              input logic [4:0] e_dest, input logic [31:0] e_data,
                              input logic [1:0] e_cnt, input logic [31:0] e_mask);
    vec_t t;
    t.sv = sv; t.sd = sd; t.sdat = sdat;
    t.vv = vv; t.vd = vd; t.vdat = vdat; t.vn = vn;
    t.e_rdy = e_rdy; t.e_en = e_en; t.e_dest = e_dest; t.e_data = e_data;
    t.e_cnt = e_cnt; t.e_mask = e_mask;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle: s_ready sampled before the edge, registered outputs after it.
  task automatic run(input vec_t t, input string name);
    s_valid = t.sv; s_dest = t.sd; s_data = t.sdat;
    v_valid = t.vv; v_dest = t.vd; v_data = t.vdat; v_newer = t.vn;
    #3;
    chk({name, " s_ready"}, 32'(s_ready), 32'(t.e_rdy));
    @(posedge clk);
    #1;
    chk({name, " wr_en"}, 32'(wr_en), 32'(t.e_en));
    if (t.e_en) begin
      chk({name, " wr_dest"}, 32'(wr_dest), 32'(t.e_dest));
      chk({name, " wr_data"}, wr_data, t.e_data);
    end
    chk({name, " buf_count"}, 32'(buf_count), 32'(t.e_cnt));
    chk({name, " pending_mask"}, pending_mask, t.e_mask);
  endtask

  task automatic idle_inputs();
    s_valid = 1'b0; s_dest = '0; s_data = '0;
    v_valid = 1'b0; v_dest = '0; v_data = '0; v_newer = 1'b0;
  endtask

  task automatic do_reset(input string name);
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk({name, " rst wr_en"}, 32'(wr_en), 32'h0);
    chk({name, " rst wr_dest"}, 32'(wr_dest), 32'h0);
    chk({name, " rst wr_data"}, wr_data, 32'h0);
    chk({name, " rst buf_count"}, 32'(buf_count), 32'h0);
    chk({name, " rst pending_mask"}, pending_mask, 32'h0);
    chk({name, " rst s_ready"}, 32'(s_ready), 32'h0);
  endtask

  // Prime dest 7, then stream vectors 8.. against a blocked scalar dest 2;
  // leaves the buffer full with entries 11 and 12.
  task automatic starve_prefix(input string name);
    run(mk(1, 5'd1, 32'h1111, 1, 5'd7, 32'h107, 1, 1, 1, 5'd1, 32'h1111, 2'd1, 32'h1 << 7),
        {name, " prime"});
    for (int k = 0; k < 4; k++)
      run(mk(1, 5'd2, 32'h2222, 1, 5'(8 + k), 32'h108 + 32'(k), 1,
             0, 1, 5'(7 + k), 32'h107 + 32'(k), 2'd1, 32'h1 << (8 + k)),
          $sformatf("%s blk%0d", name, k));
    run(mk(1, 5'd2, 32'h2222, 1, 5'd12, 32'h10C, 1, 1, 1, 5'd2, 32'h2222, 2'd2,
           (32'h1 << 11) | (32'h1 << 12)), {name, " override"});
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if (buf_count > 2'd2) begin
        failures++;
        $display("FAIL overflow: buf_count got %0d expected <= 2", buf_count);
      end
    end
  end

  vec_t tbl [15];

  initial begin
    tbl[0]  = mk(1, 5'd3, 32'hA5, 0, 5'd0, 32'h0,  0, 1, 1, 5'd3, 32'hA5, 2'd0, 32'h0);
    tbl[1]  = mk(0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 0, 0, 5'd0, 32'h0,  2'd0, 32'h0);
    tbl[2]  = mk(1, 5'd4, 32'h11, 1, 5'd5, 32'h22, 1, 1, 1, 5'd4, 32'h11, 2'd1, 32'h20);
    tbl[3]  = mk(0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 0, 1, 5'd5, 32'h22, 2'd0, 32'h0);
    tbl[4]  = mk(1, 5'd4, 32'h11, 1, 5'd5, 32'h22, 0, 0, 1, 5'd5, 32'h22, 2'd0, 32'h0);
    tbl[5]  = mk(1, 5'd4, 32'h11, 0, 5'd0, 32'h0,  0, 1, 1, 5'd4, 32'h11, 2'd0, 32'h0);
    tbl[6]  = mk(0, 5'd0, 32'h0,  1, 5'd9, 32'h99, 0, 0, 1, 5'd9, 32'h99, 2'd0, 32'h0);
    tbl[7]  = mk(0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 0, 0, 5'd0, 32'h0,  2'd0, 32'h0);
    tbl[8]  = mk(1, 5'd6, 32'h66, 1, 5'd6, 32'h77, 0, 0, 1, 5'd6, 32'h77, 2'd0, 32'h0);
    tbl[9]  = mk(1, 5'd6, 32'h66, 1, 5'd6, 32'h78, 1, 1, 1, 5'd6, 32'h66, 2'd1, 32'h40);
    tbl[10] = mk(0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 0, 1, 5'd6, 32'h78, 2'd0, 32'h0);
    tbl[11] = mk(1, 5'd1, 32'h10, 1, 5'd2, 32'h20, 1, 1, 1, 5'd1, 32'h10, 2'd1, 32'h4);
    tbl[12] = mk(1, 5'd3, 32'h30, 0, 5'd0, 32'h0,  0, 0, 1, 5'd2, 32'h20, 2'd0, 32'h0);
    tbl[13] = mk(1, 5'd3, 32'h30, 0, 5'd0, 32'h0,  0, 1, 1, 5'd3, 32'h30, 2'd0, 32'h0);
    tbl[14] = mk(0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 0, 0, 5'd0, 32'h0,  2'd0, 32'h0);

    do_reset("basic");
    for (int i = 0; i < 15; i++)
      run(tbl[i], $sformatf("tbl[%0d]", i));

    // Starvation, then a full buffer blocks override until a vector bubble.
    do_reset("starve");
    starve_prefix("starve");
    for (int j = 0; j < 5; j++)
      run(mk(1, 5'd5, 32'h5555, 1, 5'(13 + j), 32'h10D + 32'(j), 1,
             0, 1, 5'(11 + j), 32'h10B + 32'(j), 2'd2,
             (32'h1 << (12 + j)) | (32'h1 << (13 + j))),
          $sformatf("full%0d", j));
    run(mk(1, 5'd5, 32'h5555, 0, 5'd0, 32'h0, 0, 0, 1, 5'd16, 32'h110, 2'd1, 32'h1 << 17),
        "bubble");
    run(mk(1, 5'd5, 32'h5555, 0, 5'd0, 32'h0, 0, 1, 1, 5'd5, 32'h5555, 2'd1, 32'h1 << 17),
        "after_bubble");
    run(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 1, 5'd17, 32'h111, 2'd0, 32'h0), "drain");

    // Scalar dest 7 must wait while a dest-7 vector entry is buffered.
    do_reset("waw");
    run(mk(1, 5'd1, 32'h1111, 1, 5'd7, 32'h107, 1, 1, 1, 5'd1, 32'h1111, 2'd1, 32'h1 << 7),
        "waw prime");
    for (int k = 0; k < 3; k++)
      run(mk(1, 5'd7, 32'h7777, 1, 5'(8 + k), 32'h108 + 32'(k), 1,
             0, 1, 5'(7 + k), 32'h107 + 32'(k), 2'd1, 32'h1 << (8 + k)),
          $sformatf("waw blk%0d", k));
    run(mk(1, 5'd7, 32'h7777, 1, 5'd7,  32'h207, 1, 0, 1, 5'd10, 32'h10A, 2'd1, 32'h1 << 7),
        "waw push7");
    run(mk(1, 5'd7, 32'h7777, 1, 5'd11, 32'h10B, 1, 0, 1, 5'd7, 32'h207, 2'd1, 32'h1 << 11),
        "waw held");
    run(mk(1, 5'd7, 32'h7777, 1, 5'd12, 32'h10C, 1, 1, 1, 5'd7, 32'h7777, 2'd2,
           (32'h1 << 11) | (32'h1 << 12)), "waw override");
    run(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 1, 5'd11, 32'h10B, 2'd1, 32'h1 << 12),
        "waw drain0");
    run(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 1, 5'd12, 32'h10C, 2'd0, 32'h0),
        "waw drain1");

    // Asynchronous reset with two buffered entries.
    do_reset("midrst");
    starve_prefix("midrst");
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    chk("midrst async wr_en", 32'(wr_en), 32'h0);
    chk("midrst async buf_count", 32'(buf_count), 32'h0);
    chk("midrst async pending_mask", pending_mask, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++)
      run(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 5'd0, 32'h0, 2'd0, 32'h0),
          $sformatf("midrst idle%0d", k));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
